fifo_syn_ctrl: RTL and testbench

Controller that shares a single `fifo_syn` instance between `NUM_PROD` producers and one consumer. It round-robin arbitrates the producers onto the FIFO write port and schedules FIFO reads into a 2-entry output buffer. The FIFO's registered read data is presented as a valid/ready stream. It issues at most one FIFO operation per cycle and sits directly in front of `fifo_syn`, driving its `cs`/`wr_en`/`rd_en`/`data_in`.

---
 rtl/fifo_syn_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_syn_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_syn_ctrl.sv
// Arbitrates NUM_PROD producers onto one fifo_syn write port and schedules reads
// into a 2-entry output buffer presented as a valid/ready stream.
module fifo_syn_ctrl #(
  parameter int NUM_PROD   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PROD-1:0]            prod_valid,
  input  logic [NUM_PROD*DATA_WIDTH-1:0] prod_data,
  output logic [NUM_PROD-1:0]            prod_ready,
  output logic                           cons_valid,
  output logic [DATA_WIDTH-1:0]          cons_data,
  input  logic                           cons_ready,
  output logic [$clog2(NUM_PROD)-1:0]    grant_id,
  output logic                           fifo_cs,
  output logic                           fifo_wr_en,
  output logic                           fifo_rd_en,
  output logic [DATA_WIDTH-1:0]          fifo_data_in,
  input  logic [DATA_WIDTH-1:0]          fifo_data_out,
  input  logic                           fifo_empty,
  input  logic                           fifo_full
);

  localparam int ID_W = $clog2(NUM_PROD);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ
  } op_e;

  op_e                   op;
  op_e                   last_op, last_op_nxt;
  logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]       winner;
  logic                  rd_inflight;
  logic [1:0]            buf_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] buf_q   [2];
  logic [DATA_WIDTH-1:0] buf_nxt [2];
  logic                  pop;
  logic                  wr_elig, rd_elig;
  logic [2:0]            occ;

  assign cons_valid = (buf_cnt != 2'd0);
  assign cons_data  = buf_q[0];
  assign pop        = cons_valid && cons_ready;

  // Occupancy the buffer will have once this cycle's pop and any returning read land.
  assign occ = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};

  // Gating with rst_n keeps every combinational output at 0 while reset is held.
  assign wr_elig = rst_n && (|prod_valid) && !fifo_full;
  assign rd_elig = rst_n && !fifo_empty && (occ < 3'd2);

  // First valid producer at or above rr_ptr, wrapping.
  always_comb begin : pick
    int idx;
    winner = rr_ptr;
    idx    = 0;
    for (int k = NUM_PROD - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_PROD;
      if (prod_valid[idx]) winner = ID_W'(idx);
    end
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    op          = OP_IDLE;
    last_op_nxt = last_op;
    if (wr_elig && rd_elig) begin
      op          = (last_op == OP_READ) ? OP_WRITE : OP_READ;
      last_op_nxt = op;
    end else if (wr_elig) begin
      op = OP_WRITE;
    end else if (rd_elig) begin
      op = OP_READ;
    end
  end

  assign fifo_wr_en   = (op == OP_WRITE);
  assign fifo_rd_en   = (op == OP_READ);
  assign fifo_cs      = fifo_wr_en | fifo_rd_en;
  assign prod_ready   = fifo_wr_en ? (NUM_PROD'(1) << winner) : '0;
  assign fifo_data_in = fifo_wr_en ? prod_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rr_ptr_nxt   = (winner == ID_W'(NUM_PROD - 1)) ? '0 : winner + ID_W'(1);

  // In-order 2-entry queue: pop shifts the tail forward, a returning read fills
  // the first free slot after that shift.
  always_comb begin
    buf_nxt = buf_q;
    cnt_nxt = buf_cnt;
    if (pop) begin
      buf_nxt[0] = buf_q[1];
      cnt_nxt    = buf_cnt - 2'd1;
    end
    if (rd_inflight) begin
      buf_nxt[cnt_nxt[0]] = fifo_data_out;
      cnt_nxt             = cnt_nxt + 2'd1;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_op     <= OP_READ;
      rr_ptr      <= '0;
      grant_id    <= '0;
      rd_inflight <= 1'b0;
      buf_cnt     <= 2'd0;
      // NOTE: the buffer storage is reset too, because cons_data must read 0 during reset.
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      last_op     <= last_op_nxt;
      rd_inflight <= fifo_rd_en;
      buf_cnt     <= cnt_nxt;
      buf_q       <= buf_nxt;
      if (fifo_wr_en) begin
        rr_ptr   <= rr_ptr_nxt;
        grant_id <= winner;
      end
    end
  end

endmodule

// File: tb/tb_fifo_syn_ctrl.sv
// Bench for fifo_syn_ctrl with a behavioural 8-deep fifo_syn and an in-order
// scoreboard fed by producer handshakes and drained by consumer handshakes.
module tb_fifo_syn_ctrl;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int IDW   = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    prod_valid = '0;
  logic [NP*DW-1:0] prod_data = '0;
  logic [NP-1:0]    prod_ready;
  logic             cons_valid;
  logic [DW-1:0]    cons_data;
  logic             cons_ready = 1'b0;
  logic [IDW-1:0]   grant_id;
  logic             fifo_cs, fifo_wr_en, fifo_rd_en;
  logic [DW-1:0]    fifo_data_in, fifo_data_out;
  logic             fifo_empty, fifo_full;

  int            total = 0;
  int            bad = 0;
  int            rx_count = 0;
  logic [DW-1:0] exp_q [$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always #5 clk = ~clk;

  fifo_syn_ctrl #(.NUM_PROD(NP), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prod_valid   (prod_valid),
    .prod_data    (prod_data),
    .prod_ready   (prod_ready),
    .cons_valid   (cons_valid),
    .cons_data    (cons_data),
    .cons_ready   (cons_ready),
    .grant_id     (grant_id),
    .fifo_cs      (fifo_cs),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data_in (fifo_data_in),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full)
  );

  // Behavioural fifo_syn: registered read data, flags from the registered count.
  logic [DW-1:0] fmem [DEPTH];
  int fcnt, frd, fwr;
  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt == DEPTH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt          <= 0;
      frd           <= 0;
      fwr           <= 0;
      fifo_data_out <= '0;
    end else begin
      if (fifo_cs && fifo_wr_en && !fifo_full) begin
        fmem[fwr] <= fifo_data_in;
        fwr       <= (fwr + 1) % DEPTH;
      end
      if (fifo_cs && fifo_rd_en && !fifo_empty) begin
        fifo_data_out <= fmem[frd];
        frd           <= (frd + 1) % DEPTH;
      end
      fcnt <= fcnt + ((fifo_cs && fifo_wr_en && !fifo_full) ? 1 : 0)
                   - ((fifo_cs && fifo_rd_en && !fifo_empty) ? 1 : 0);
    end
  end

  // Monitor: scoreboard push/pop plus protocol rules, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      for (int i = 0; i < NP; i++)
        if (prod_valid[i] && prod_ready[i]) exp_q.push_back(prod_data[i*DW +: DW]);
      total++;
      if (fifo_wr_en && fifo_rd_en) begin
        bad++;
        $display("FAIL wr_rd_both: got wr=%b rd=%b, required not both 1", fifo_wr_en, fifo_rd_en);
      end
      total++;
      if (fifo_cs !== (fifo_wr_en | fifo_rd_en)) begin
        bad++;
        $display("FAIL fifo_cs: got %b, required %b", fifo_cs, fifo_wr_en | fifo_rd_en);
      end
      if (stall_prev) begin
        total++;
        if (cons_valid !== 1'b1 || cons_data !== stall_data) begin
          bad++;
          $display("FAIL stall_stable: got v=%b %h, required v=1 %h", cons_valid, cons_data, stall_data);
        end
      end
      if (cons_valid && cons_ready) begin
        total++;
        rx_count++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cons_unexpected: got %h, required no word", cons_data);
        end else begin
          if (cons_data !== exp_q[0]) begin
            bad++;
            $display("FAIL cons_data: got %h, required %h", cons_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      stall_prev = cons_valid && !cons_ready;
      stall_data = cons_data;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    prod_valid = '0;
    prod_data  = '0;
    cons_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int want_rx);
    int base = rx_count;
    prod_valid = '0;
    cons_ready = 1'b1;
    for (int c = 0; c < 60 && (rx_count - base) < want_rx; c++) @(negedge clk);
    total++;
    if (rx_count - base !== want_rx) begin
      bad++;
      $display("FAIL %s_drain: got %0d words, required %0d", name, rx_count - base, want_rx);
    end
    cons_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    prod_valid = '1;
    prod_data  = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    cons_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (prod_ready !== '0) begin
        bad++;
        $display("FAIL rst_prod_ready: got %b, required 0000", prod_ready);
      end
      total++;
      if ({fifo_cs, fifo_wr_en, fifo_rd_en} !== 3'b000) begin
        bad++;
        $display("FAIL rst_fifo_ctl: got %b, required 000", {fifo_cs, fifo_wr_en, fifo_rd_en});
      end
      total++;
      if ({cons_valid, cons_data, grant_id, fifo_data_in} !== '0) begin
        bad++;
        $display("FAIL rst_outputs: got v=%b d=%h g=%0d din=%h, required all 0",
                 cons_valid, cons_data, grant_id, fifo_data_in);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (prod_ready !== 4'b0001) begin
      bad++;
      $display("FAIL first_grant: got %b, required 0001", prod_ready);
    end
    total++;
    if (fifo_data_in !== 32'h1000_0000) begin
      bad++;
      $display("FAIL first_data_in: got %h, required 10000000", fifo_data_in);
    end
    @(negedge clk);
    #1;
    total++;
    if (grant_id !== 2'd0) begin
      bad++;
      $display("FAIL first_grant_id: got %0d, required 0", grant_id);
    end
    prod_valid = '0;
  endtask

  task automatic test_rr_fill();
    int  pcnt [NP];
    int  exp_ptr = 0;
    int  accepted = 0;
    int  prev_win = 0;
    bit  prev_acc = 1'b0;
    for (int i = 0; i < NP; i++) pcnt[i] = 0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      prod_valid = '1;
      cons_ready = 1'b0;
      for (int i = 0; i < NP; i++) prod_data[i*DW +: DW] = {4'(i + 1), 28'(pcnt[i])};
      #1;
      if (prev_acc) begin
        total++;
        if (grant_id !== IDW'(prev_win)) begin
          bad++;
          $display("FAIL rr_grant_id: got %0d, required %0d", grant_id, prev_win);
        end
      end
      prev_acc = 1'b0;
      if (prod_ready != '0) begin
        total++;
        if (prod_ready !== (NP'(1) << exp_ptr)) begin
          bad++;
          $display("FAIL rr_order: got %b, required %b", prod_ready, NP'(1) << exp_ptr);
        end
        total++;
        if (fifo_data_in !== {4'(exp_ptr + 1), 28'(pcnt[exp_ptr])}) begin
          bad++;
          $display("FAIL rr_data_in: got %h, required %h", fifo_data_in,
                   {4'(exp_ptr + 1), 28'(pcnt[exp_ptr])});
        end
        pcnt[exp_ptr]++;
        prev_win = exp_ptr;
        prev_acc = 1'b1;
        accepted++;
        exp_ptr  = (exp_ptr + 1) % NP;
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (accepted !== 10) begin
      bad++;
      $display("FAIL rr_accepted: got %0d, required 10", accepted);
    end
    total++;
    if (fifo_full !== 1'b1 || prod_ready !== '0) begin
      bad++;
      $display("FAIL rr_full: got full=%b ready=%b, required full=1 ready=0000", fifo_full, prod_ready);
    end
    total++;
    if (cons_valid !== 1'b1 || cons_data !== 32'h1000_0000) begin
      bad++;
      $display("FAIL rr_head: got v=%b %h, required v=1 10000000", cons_valid, cons_data);
    end
    @(negedge clk);
    drain("rr", 10);
  endtask

  task automatic test_contention();
    int n = 0;
    bit exp_wr;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      prod_valid = 4'b0100;
      prod_data[2*DW +: DW] = 32'hA000_0000 + 32'(n);
      cons_ready = 1'b1;
      #1;
      exp_wr = (c == 0) || (c % 2 == 1);
      total++;
      if (fifo_wr_en !== exp_wr || fifo_rd_en !== !exp_wr) begin
        bad++;
        $display("FAIL contention_c%0d: got wr=%b rd=%b, required wr=%b rd=%b",
                 c, fifo_wr_en, fifo_rd_en, exp_wr, !exp_wr);
      end
      if (prod_ready[2]) n++;
      @(negedge clk);
    end
    drain("contention", exp_q.size());
  endtask

  task automatic test_back_to_back_backpressure();
    int n = 0;
    int base;
    do_reset();
    base = rx_count;
    for (int c = 0; c < 400 && (rx_count - base) < 8; c++) begin
      prod_valid = (n < 8) ? 4'b0010 : 4'b0000;
      prod_data[DW +: DW] = 32'h1000_0000 + 32'(n);
      cons_ready = 1'($urandom_range(0, 1));
      #1;
      if (prod_valid[1] && prod_ready[1]) n++;
      @(negedge clk);
    end
    total++;
    if (rx_count - base !== 8) begin
      bad++;
      $display("FAIL bp_received: got %0d words, required 8", rx_count - base);
    end
    prod_valid = '0;
    cons_ready = 1'b0;
  endtask

  task automatic test_empty_idle();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      prod_valid = '0;
      cons_ready = 1'(c % 2);
      #1;
      total++;
      if (fifo_rd_en !== 1'b0 || cons_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_c%0d: got rd=%b v=%b, required 0 0", c, fifo_rd_en, cons_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    prod_valid = 4'b0001;
    prod_data[0 +: DW] = 32'hDEAD_0001;
    cons_ready = 1'b0;
    @(negedge clk);
    prod_valid = '0;
    #1;
    total++;
    if (fifo_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL midrd_issue: got rd=%b, required 1", fifo_rd_en);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (cons_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrd_reset_valid: got %b, required 0", cons_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (cons_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrd_stale_c%0d: got v=%b d=%h, required v=0", c, cons_valid, cons_data);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rr_fill();
    test_contention();
    test_back_to_back_backpressure();
    test_empty_idle();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
